mips_avalon_ram: RTL

- Avalon-MM slave (responder) word memory that answers the CPU bus master.
- Used as instruction+data memory in the CPU testbench and in FPGA bring-up.
- Fixed, parameterised wait-state latency plus an external stall input, so the master's waitrequest handling can be exercised.
- Word-addressed internally; byte lanes on writes via byteenable.

---
 rtl/mips_bus_pkg.sv | 24 ++
 rtl/mips_ram_array.sv | 42 ++++
 rtl/mips_avalon_ram.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mips_bus_pkg.sv
// Shared CPU bus definitions: reset vector, byte-lane constants and the
// state type of the Avalon word-memory responder.
package mips_bus_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;

  localparam logic [LANES-1:0] BE_NONE = 4'b0000;
  localparam logic [LANES-1:0] BE_B0   = 4'b0001;
  localparam logic [LANES-1:0] BE_B1   = 4'b0010;
  localparam logic [LANES-1:0] BE_B2   = 4'b0100;
  localparam logic [LANES-1:0] BE_B3   = 4'b1000;
  localparam logic [LANES-1:0] BE_ALL  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } ram_state_t;

endpackage

// File: rtl/mips_ram_array.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port that can be synchronously cleared.
module mips_ram_array
  import mips_bus_pkg::*;
#(
  parameter int unsigned WORDS = 1024,
  localparam int unsigned AW   = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr_i,
  input  logic              we_i,
  input  logic [LANES-1:0]  be_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane write port
  always_ff @(posedge clk) begin
    for (int n = 0; n < int'(LANES); n++) begin
      if (we_i && be_i[n]) begin
        mem_q[addr_i][LANE_W*n +: LANE_W] <= wdata_i[LANE_W*n +: LANE_W];
      end
    end
  end

  // Read register; clear has priority so out-of-range reads return zero
  always_ff @(posedge clk) begin
    if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_avalon_ram.sv
// Avalon-MM word memory responder with fixed wait states, a bench stall
// input and a sticky protocol/range error flag.
module mips_avalon_ram
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              read,
  input  logic              write,
  input  logic [LANES-1:0]  byteenable,
  input  logic [DATA_W-1:0] writedata,
  output logic              waitrequest,
  output logic [DATA_W-1:0] readdata,
  input  logic              stall,
  output logic              err
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = 4;

  ram_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [LANES-1:0]  be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  logic [31:0]       cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [LANES-1:0]  cur_be;
  logic              cur_rd, cur_wr;
  logic [31:0]       offset;
  logic              in_range, bad_req, changed, complete;
  logic              ram_we, ram_re, ram_clr;

  assign waitrequest = !reset || ((read || write) && (state_q != ACK));

  // Request under service: live bus while IDLE, latched copy afterwards
  always_comb begin
    cur_addr  = addr_q;
    cur_rd    = rd_q;
    cur_wr    = wr_q;
    cur_be    = be_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_addr  = address;
      cur_rd    = read;
      cur_wr    = write;
      cur_be    = byteenable;
      cur_wdata = writedata;
    end
    offset   = cur_addr - BASE_ADDR;
    in_range = (cur_addr >= BASE_ADDR) && ((offset >> 2) < 32'(MEM_WORDS));
    bad_req  = !in_range || (cur_addr[1:0] != 2'b00) || (cur_rd && cur_wr);
    changed  = (read != rd_q) || (write != wr_q) || (address != addr_q) ||
               (wr_q && ((byteenable != be_q) || (writedata != wdata_q)));
  end

  // Next state; the IDLE cycle that sees the request is the first wait cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (read || write) begin
          addr_d  = address;
          rd_d    = read;
          wr_d    = write;
          be_d    = byteenable;
          wdata_d = writedata;
          if (WAIT_CYCLES <= 1) begin
            complete = 1'b1;
            state_d  = ACK;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(WAIT_CYCLES - 2);
          end
        end
      end
      WAIT: begin
        if (changed) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (!stall) begin
          if (cnt_q == '0) begin
            complete = 1'b1;
            state_d  = ACK;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (complete && bad_req) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Simultaneous read+write is serviced as a write
  assign ram_we  = reset && complete && cur_wr && in_range;
  assign ram_re  = reset && complete && !cur_wr && in_range;
  assign ram_clr = !reset || (complete && !cur_wr && !in_range);

  mips_ram_array #(
    .WORDS (MEM_WORDS)
  ) u_array (
    .clk     (clk),
    .addr_i  (offset[AW+1:2]),
    .we_i    (ram_we),
    .be_i    (cur_be),
    .wdata_i (cur_wdata),
    .re_i    (ram_re),
    .clr_i   (ram_clr),
    .rdata_o (readdata)
  );

  assign err = err_q;

endmodule
